// File: rtl/neighbour_counter_pkg.sv
// Shared constants and FSM encoding for the neighbour counter.
package neighbour_counter_pkg;
  localparam int MAX_DIM    = 16;
  localparam int CNT_W      = 4;
  localparam int IDX_W      = 4;
  localparam int DIM_EASY   = 8;
  localparam int DIM_MEDIUM = 10;
  localparam int DIM_HARD   = 16;

  typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/neighbour_counter_if.sv
// Control, board and read-port bundle between the game logic and the counter.
interface neighbour_counter_if;
  import neighbour_counter_pkg::*;
  logic                         start;
  logic [4:0]                   dimension_size;
  logic [MAX_DIM*MAX_DIM-1:0]   mine_map;
  logic                         busy;
  logic                         done;
  logic [IDX_W-1:0]             rd_x;
  logic [IDX_W-1:0]             rd_y;
  logic [CNT_W-1:0]             rd_count;
  logic                         rd_mine;

  modport master (output start, dimension_size, mine_map, rd_x, rd_y,
                  input  busy, done, rd_count, rd_mine);
  modport slave  (input  start, dimension_size, mine_map, rd_x, rd_y,
                  output busy, done, rd_count, rd_mine);
endinterface

// File: rtl/neighbour_counter_sum.sv
// Combinational 8-neighbour mine count for one cell, masked to the active dim x dim board.
module neighbour_sum
  import neighbour_counter_pkg::*;
(
  input  logic [MAX_DIM*MAX_DIM-1:0] snap,
  input  logic [IDX_W-1:0]           x,
  input  logic [IDX_W-1:0]           y,
  input  logic [4:0]                 dim,
  output logic [CNT_W-1:0]           sum
);
  int         nx, ny;
  logic [7:0] idx;

  always_comb begin
    sum = '0;
    nx  = 0;
    ny  = 0;
    idx = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(x) + dx;
        ny = int'(y) + dy;
        // No wrap: neighbours off the active board contribute nothing.
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < int'(dim) &&
            ny >= 0 && ny < int'(dim)) begin
          idx = 8'(ny * MAX_DIM + nx);
          if (snap[idx]) sum = sum + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/neighbour_counter.sv
// Scans a snapshotted mine map one cell per clock and serves per-cell neighbour counts.
module neighbour_counter
  import neighbour_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  neighbour_counter_if.slave bus
);
  state_t                     state, state_n;
  logic [IDX_W-1:0]           x, y;
  logic [4:0]                 dim, dim_req;
  logic [MAX_DIM*MAX_DIM-1:0] snap;
  logic [CNT_W-1:0]           cnt [MAX_DIM][MAX_DIM];
  logic [CNT_W-1:0]           sum;
  logic                       busy_q, done_q;
  logic [CNT_W-1:0]           rd_count_q;
  logic                       rd_mine_q;
  logic                       accept, x_last, last, rd_in;

  neighbour_sum u_sum (.snap(snap), .x(x), .y(y), .dim(dim), .sum(sum));

  assign dim_req = (bus.dimension_size > 5'd16) ? 5'd16 : bus.dimension_size;
  assign x_last  = ({1'b0, x} == dim - 5'd1);
  assign last    = x_last && ({1'b0, y} == dim - 5'd1);
  assign rd_in   = ({1'b0, bus.rd_x} < dim) && ({1'b0, bus.rd_y} < dim);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept = 1'b1;
        if (dim_req > 5'd1) state_n = SCAN;
      end
      SCAN: if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      dim        <= '0;
      snap       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_count_q <= '0;
      rd_mine_q  <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++)
        for (int j = 0; j < MAX_DIM; j++) cnt[i][j] <= '0;
    end else begin
      state  <= state_n;
      done_q <= 1'b0;
      if (accept) begin
        snap   <= bus.mine_map;
        dim    <= dim_req;
        x      <= '0;
        y      <= '0;
        busy_q <= (dim_req > 5'd1);
        // Degenerate boards complete immediately with all counts zero.
        done_q <= (dim_req <= 5'd1);
        for (int i = 0; i < MAX_DIM; i++)
          for (int j = 0; j < MAX_DIM; j++) cnt[i][j] <= '0;
      end else if (state == SCAN) begin
        cnt[y][x] <= sum;
        if (x_last) begin
          x <= '0;
          y <= y + IDX_W'(1);
        end else begin
          x <= x + IDX_W'(1);
        end
        if (last) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
      // Non-blocking read sees the pre-write value of a cell updated this cycle.
      rd_count_q <= rd_in ? cnt[bus.rd_y][bus.rd_x] : '0;
      rd_mine_q  <= rd_in ? snap[{bus.rd_y, bus.rd_x}] : 1'b0;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_count = rd_count_q;
  assign bus.rd_mine  = rd_mine_q;
endmodule

// File: tb/tb_neighbour_counter.sv
// Directed bench for neighbour_counter: scan timing, boundary masking, snapshot and reset.
module tb_neighbour_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  neighbour_counter_if bus ();
  neighbour_counter dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rd(input int x, input int y, input int ec, input int em, input string tag);
    @(negedge clk);
    bus.rd_x = 4'(x);
    bus.rd_y = 4'(y);
    @(posedge clk); #1;
    chk({tag, "_cnt"},  int'(bus.rd_count), ec);
    chk({tag, "_mine"}, int'(bus.rd_mine),  em);
  endtask

  task automatic do_start(input int d, input logic [255:0] m);
    @(negedge clk);
    bus.dimension_size = 5'(d);
    bus.mine_map       = m;
    bus.start          = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Waits for done; optionally changes the map and pulses start mid-scan.
  task automatic run_scan(input int exp, input int pulse_at, input logic [255:0] alt,
                          input string tag);
    int  nb, cyc;
    bit  seen;
    nb   = bus.busy ? 1 : 0;
    cyc  = -1;
    seen = 0;
    for (int c = 1; c <= 600 && !seen; c++) begin
      if (c == pulse_at) begin
        bus.mine_map = alt;
        bus.start    = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        seen = 1;
        cyc  = c;
        chk({tag, "_busy_at_done"}, int'(bus.busy), 0);
      end else if (bus.busy) nb++;
    end
    chk({tag, "_done_cycle"}, cyc, exp);
    chk({tag, "_busy_cycles"}, nb, exp);
  endtask

  initial begin
    logic [255:0] m, alt;
    int           e, dn;
    bit           bx, by;
    bus.start = 0; bus.dimension_size = 0; bus.mine_map = '0;
    bus.rd_x = 0; bus.rd_y = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_cnt",  int'(bus.rd_count), 0);
    chk("rst_mine", int'(bus.rd_mine), 0);
    @(negedge clk); rst = 0;

    // Single interior mine at (3,3), dim 8
    m = '0; m[3*16+3] = 1'b1;
    do_start(8, m);
    run_scan(64, -1, '0, "interior");
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        e = (x >= 2 && x <= 4 && y >= 2 && y <= 4 && !(x == 3 && y == 3)) ? 1 : 0;
        rd(x, y, e, (x == 3 && y == 3) ? 1 : 0, $sformatf("int(%0d,%0d)", x, y));
      end

    // Corner mine, dim 10, no wrap-around
    m = '0; m[0] = 1'b1;
    do_start(10, m);
    run_scan(100, -1, '0, "corner");
    rd(1, 0, 1, 0, "c(1,0)");
    rd(0, 1, 1, 0, "c(0,1)");
    rd(1, 1, 1, 0, "c(1,1)");
    rd(0, 0, 0, 1, "c(0,0)");
    rd(9, 9, 0, 0, "c(9,9)");
    rd(9, 0, 0, 0, "c(9,0)");
    rd(0, 9, 0, 0, "c(0,9)");

    // Full 8x8 board
    m = '0;
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) m[y*16+x] = 1'b1;
    do_start(8, m);
    run_scan(64, -1, '0, "full");
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        bx = (x == 0 || x == 7);
        by = (y == 0 || y == 7);
        e  = (bx && by) ? 3 : ((bx || by) ? 5 : 8);
        rd(x, y, e, 1, $sformatf("full(%0d,%0d)", x, y));
      end
    rd(8, 0, 0, 0, "full_oob_x8");
    rd(3, 12, 0, 0, "full_oob_y12");

    // Bits outside dim are ignored, then visible at dim 16
    m = '0; m[8] = 1'b1; m[8*16] = 1'b1;
    do_start(8, m);
    run_scan(64, -1, '0, "oob8");
    rd(7, 0, 0, 0, "oob8(7,0)");
    rd(7, 1, 0, 0, "oob8(7,1)");
    rd(0, 7, 0, 0, "oob8(0,7)");
    rd(1, 7, 0, 0, "oob8(1,7)");
    do_start(16, m);
    run_scan(256, -1, '0, "oob16");
    rd(7, 0, 1, 0, "oob16(7,0)");
    rd(7, 1, 1, 0, "oob16(7,1)");
    rd(0, 7, 1, 0, "oob16(0,7)");
    rd(1, 7, 1, 0, "oob16(1,7)");
    rd(8, 0, 0, 1, "oob16(8,0)");
    rd(15, 15, 0, 0, "oob16(15,15)");

    // Snapshot held and start ignored while busy
    m = '0; m[5*16+5] = 1'b1;
    alt = '1;
    do_start(16, m);
    run_scan(256, 10, alt, "snap");
    rd(4, 4, 1, 0, "snap(4,4)");
    rd(5, 5, 0, 1, "snap(5,5)");
    rd(6, 5, 1, 0, "snap(6,5)");
    rd(0, 0, 0, 0, "snap(0,0)");
    rd(15, 15, 0, 0, "snap(15,15)");

    // Reset in the middle of a scan
    m = '0; m[3*16+3] = 1'b1;
    do_start(8, m);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", int'(bus.busy), 0);
    dn = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk("mid_rst_no_done", dn, 0);
    rd(2, 2, 0, 0, "mrst(2,2)");
    rd(3, 3, 0, 0, "mrst(3,3)");
    rd(0, 0, 0, 0, "mrst(0,0)");
    do_start(8, m);
    run_scan(64, -1, '0, "restart");
    rd(2, 2, 1, 0, "rs(2,2)");
    rd(4, 4, 1, 0, "rs(4,4)");
    rd(3, 3, 0, 1, "rs(3,3)");
    rd(5, 5, 0, 0, "rs(5,5)");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
